// File: rtl/puerta_motor_drv_if.sv
// Door-FSM to motor-driver bundle: motor requests, limits and fault clear in,
// H-bridge drive, duty and state out.
interface puerta_motor_drv_if #(
   parameter int PWM_W = 8
);
   logic             ena;
   logic             ma_req;
   logic             mc_req;
   logic             la;
   logic             lc;
   logic             clr_fault;
   logic             pwm_open;
   logic             pwm_close;
   logic             brake;
   logic             fault;
   logic [PWM_W-1:0] duty;
   logic [2:0]       state;

   modport master (
      output ena, ma_req, mc_req, la, lc, clr_fault,
      input  pwm_open, pwm_close, brake, fault, duty, state
   );

   modport slave (
      input  ena, ma_req, mc_req, la, lc, clr_fault,
      output pwm_open, pwm_close, brake, fault, duty, state
   );
endinterface

// File: rtl/puerta_motor_drv.sv
// H-bridge driver for the door motor: dead-time, soft-start ramp, limit cutoff,
// run timeout and latched fault. MOTOR_SOFTSTART_EN enables the duty ramp.
module puerta_motor_drv #(
   parameter int DEAD_CYC = 16,
   parameter int PWM_W    = 8,
   parameter int RAMP_DIV = 4,
   parameter int TIMEOUT  = 1000000
) (
   input logic               clk,
   input logic               rst,
   puerta_motor_drv_if.slave bus
);
   localparam int DW = $clog2(DEAD_CYC + 1);
   localparam int TW = $clog2(TIMEOUT + 1);
   localparam logic [PWM_W-1:0] DUTY_MAX  = {PWM_W{1'b1}};
   localparam logic [DW-1:0]    DEAD_LAST = DW'(DEAD_CYC - 1);
   localparam logic [TW-1:0]    RUN_LAST  = TW'(TIMEOUT - 1);

   if (DEAD_CYC < 1 || RAMP_DIV < 1 || TIMEOUT < 2) begin : g_bad_param
      $error("puerta_motor_drv: DEAD_CYC>=1, RAMP_DIV>=1, TIMEOUT>=2 required");
   end

`ifdef MOTOR_SOFTSTART_EN
   localparam int RW = $clog2(RAMP_DIV + 1);
   localparam logic [RW-1:0]    RAMP_LAST  = RW'(RAMP_DIV - 1);
   localparam logic [PWM_W-1:0] ENTRY_DUTY = '0;
   logic [RW-1:0] ramp_cnt;
`else
   localparam logic [PWM_W-1:0] ENTRY_DUTY = DUTY_MAX;
`endif

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_DEAD  = 3'd1,
      S_OPEN  = 3'd2,
      S_CLOSE = 3'd3,
      S_FAULT = 3'd4
   } st_t;

   st_t              st;
   logic             dir_close;
   logic [PWM_W-1:0] pwm_cnt;
   logic [PWM_W-1:0] duty_r;
   logic [DW-1:0]    dead_cnt;
   logic [TW-1:0]    run_cnt;
   logic             pwm_open_q, pwm_close_q, brake_q, fault_q;

   logic both_req, own_req, own_lim, opp_req, drive;
   assign both_req = bus.ma_req & bus.mc_req;
   assign own_req  = dir_close ? bus.mc_req : bus.ma_req;
   assign own_lim  = dir_close ? bus.lc : bus.la;
   assign opp_req  = dir_close ? bus.ma_req : bus.mc_req;
   assign drive    = (duty_r == DUTY_MAX) || (pwm_cnt < duty_r);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         st          <= S_IDLE;
         dir_close   <= 1'b0;
         pwm_cnt     <= '0;
         duty_r      <= '0;
         dead_cnt    <= '0;
         run_cnt     <= '0;
`ifdef MOTOR_SOFTSTART_EN
         ramp_cnt    <= '0;
`endif
         pwm_open_q  <= 1'b0;
         pwm_close_q <= 1'b0;
         brake_q     <= 1'b1;
         fault_q     <= 1'b0;
      end else if (!bus.ena) begin
         // Frozen: state and counters hold, bridge parked in brake.
         pwm_open_q  <= 1'b0;
         pwm_close_q <= 1'b0;
         brake_q     <= 1'b1;
      end else begin
         pwm_cnt     <= pwm_cnt + 1'b1;
         pwm_open_q  <= (st == S_OPEN) && drive;
         pwm_close_q <= (st == S_CLOSE) && drive;
         brake_q     <= (st == S_IDLE) || (st == S_FAULT);
         fault_q     <= (st == S_FAULT);
         case (st)
            S_IDLE: begin
               duty_r <= '0;
               if (both_req) st <= S_FAULT;
               else if (bus.ma_req && !bus.la) begin
                  st <= S_DEAD; dir_close <= 1'b0; dead_cnt <= '0;
               end else if (bus.mc_req && !bus.lc) begin
                  st <= S_DEAD; dir_close <= 1'b1; dead_cnt <= '0;
               end
            end
            S_DEAD: begin
               duty_r <= '0;
               if (both_req) st <= S_FAULT;
               else if (own_lim || !own_req) st <= S_IDLE;
               else if (dead_cnt == DEAD_LAST) begin
                  st      <= dir_close ? S_CLOSE : S_OPEN;
                  run_cnt <= '0;
                  duty_r  <= ENTRY_DUTY;
`ifdef MOTOR_SOFTSTART_EN
                  ramp_cnt <= '0;
`endif
               end else dead_cnt <= dead_cnt + 1'b1;
            end
            S_OPEN, S_CLOSE: begin
               if (both_req) begin
                  st <= S_FAULT; duty_r <= '0;
               end else if (own_lim) begin
                  st <= S_IDLE; duty_r <= '0;
               end else if (opp_req) begin
                  // Reversal always passes back through the dead-time.
                  st <= S_DEAD; dir_close <= !dir_close; dead_cnt <= '0; duty_r <= '0;
               end else if (!own_req) begin
                  st <= S_IDLE; duty_r <= '0;
               end else if (run_cnt == RUN_LAST) begin
                  st <= S_FAULT; duty_r <= '0;
               end else begin
                  run_cnt <= run_cnt + 1'b1;
`ifdef MOTOR_SOFTSTART_EN
                  if (ramp_cnt == RAMP_LAST) begin
                     ramp_cnt <= '0;
                     if (duty_r != DUTY_MAX) duty_r <= duty_r + 1'b1;
                  end else ramp_cnt <= ramp_cnt + 1'b1;
`endif
               end
            end
            S_FAULT: begin
               duty_r <= '0;
               if (bus.clr_fault && !bus.ma_req && !bus.mc_req) st <= S_IDLE;
            end
            default: st <= S_IDLE;
         endcase
      end
   end

   assign bus.pwm_open  = pwm_open_q;
   assign bus.pwm_close = pwm_close_q;
   assign bus.brake     = brake_q;
   assign bus.fault     = fault_q;
   assign bus.duty      = duty_r;
   assign bus.state     = st;
endmodule

// File: tb/tb_puerta_motor_drv.sv
// Directed bench for puerta_motor_drv with DEAD_CYC=4, RAMP_DIV=2, TIMEOUT=50.
module tb_puerta_motor_drv;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   failures = 0;

`ifdef MOTOR_SOFTSTART_EN
   localparam logic [7:0] ENTRY = 8'd0;
`else
   localparam logic [7:0] ENTRY = 8'd255;
`endif

   puerta_motor_drv_if #(.PWM_W(8)) bus ();

   puerta_motor_drv #(.DEAD_CYC(4), .PWM_W(8), .RAMP_DIV(2), .TIMEOUT(50)) dut (
      .clk(clk), .rst(rst), .bus(bus)
   );

   always #5 clk = ~clk;

   always @(negedge clk) if (!rst) begin
      checks++;
      if (bus.pwm_open && bus.pwm_close) begin
         failures++; $display("FAIL both_legs pwm_open=1 pwm_close=1 required not both");
      end
   end

   task automatic tick(input int n);
      repeat (n) begin @(posedge clk); #1; end
   endtask

   task automatic clear_inputs();
      bus.ma_req = 0; bus.mc_req = 0; bus.la = 0; bus.lc = 0; bus.clr_fault = 0; bus.ena = 1;
   endtask

   task automatic test_reset();
      clear_inputs();
      tick(2);
      checks++;
      if ({bus.state, bus.duty, bus.pwm_open, bus.pwm_close, bus.brake, bus.fault} !== {3'd0, 8'd0, 4'b0010}) begin
         failures++; $display("FAIL reset state=%0d duty=%0d po=%b pc=%b brk=%b flt=%b required 0 0 0 0 1 0",
            bus.state, bus.duty, bus.pwm_open, bus.pwm_close, bus.brake, bus.fault);
      end
      rst = 0;
      tick(2);
   endtask

   task automatic test_open_ramp();
      bus.ma_req = 1;
      tick(1);
      checks++;
      if (bus.state !== 3'd1) begin failures++; $display("FAIL dead_entry state=%0d required 1", bus.state); end
      tick(3);
      checks++;
      if (bus.state !== 3'd1 || bus.brake !== 1'b0) begin
         failures++; $display("FAIL dead_hold state=%0d brake=%b required 1 0", bus.state, bus.brake);
      end
      tick(1);
      checks++;
      if (bus.state !== 3'd2 || bus.duty !== ENTRY) begin
         failures++; $display("FAIL run_entry state=%0d duty=%0d required 2 %0d", bus.state, bus.duty, ENTRY);
      end
      for (int i = 0; i < 4; i++) begin
         logic [7:0] exp_duty;
         logic       exp_open;
`ifdef MOTOR_SOFTSTART_EN
         exp_duty = 8'((i + 1) / 2);
         exp_open = (i == 0) ? 1'b0 : bus.pwm_open;
`else
         exp_duty = 8'd255;
         exp_open = 1'b1;
`endif
         tick(1);
`ifdef MOTOR_SOFTSTART_EN
         if (i != 0) exp_open = bus.pwm_open;
`endif
         checks++;
         if (bus.duty !== exp_duty || bus.pwm_open !== exp_open || bus.pwm_close !== 1'b0) begin
            failures++; $display("FAIL ramp[%0d] duty=%0d po=%b pc=%b required %0d %b 0",
               i, bus.duty, bus.pwm_open, bus.pwm_close, exp_duty, exp_open);
         end
      end
   endtask

   task automatic test_limit();
      bus.la = 1;
      tick(1);
      checks++;
      if (bus.state !== 3'd0) begin failures++; $display("FAIL limit_idle state=%0d required 0", bus.state); end
      tick(1);
      checks++;
      if (bus.pwm_open !== 1'b0 || bus.brake !== 1'b1 || bus.duty !== 8'd0) begin
         failures++; $display("FAIL limit_brake po=%b brk=%b duty=%0d required 0 1 0", bus.pwm_open, bus.brake, bus.duty);
      end
      tick(3);
      checks++;
      if (bus.state !== 3'd0) begin failures++; $display("FAIL limit_hold state=%0d required 0", bus.state); end
      clear_inputs();
      tick(1);
   endtask

   task automatic test_reversal();
      bus.ma_req = 1;
      tick(5);
      checks++;
      if (bus.state !== 3'd2) begin failures++; $display("FAIL rev_open state=%0d required 2", bus.state); end
      bus.ma_req = 0; bus.mc_req = 1;
      tick(1);
      checks++;
      if (bus.state !== 3'd1) begin failures++; $display("FAIL rev_dead state=%0d required 1", bus.state); end
      for (int i = 0; i < 3; i++) begin
         tick(1);
         checks++;
         if (bus.state !== 3'd1 || bus.pwm_open !== 1'b0 || bus.pwm_close !== 1'b0) begin
            failures++; $display("FAIL rev_dead_legs[%0d] state=%0d po=%b pc=%b required 1 0 0",
               i, bus.state, bus.pwm_open, bus.pwm_close);
         end
      end
      tick(1);
      checks++;
      if (bus.state !== 3'd3 || bus.duty !== ENTRY || bus.pwm_close !== 1'b0) begin
         failures++; $display("FAIL rev_close state=%0d duty=%0d pc=%b required 3 %0d 0", bus.state, bus.duty, bus.pwm_close, ENTRY);
      end
      tick(1);
      checks++;
      if (bus.pwm_open !== 1'b0 || bus.pwm_close !== (ENTRY == 8'd255)) begin
         failures++; $display("FAIL rev_drive po=%b pc=%b required 0 %b", bus.pwm_open, bus.pwm_close, ENTRY == 8'd255);
      end
      bus.mc_req = 0;
      tick(2);
      checks++;
      if (bus.state !== 3'd0) begin failures++; $display("FAIL rev_drop state=%0d required 0", bus.state); end
   endtask

   task automatic test_timeout();
      bus.ma_req = 1;
      tick(5);
      tick(49);
      checks++;
      if (bus.state !== 3'd2) begin failures++; $display("FAIL tmo_early state=%0d required 2", bus.state); end
      tick(1);
      checks++;
      if (bus.state !== 3'd4) begin failures++; $display("FAIL tmo_fault state=%0d required 4", bus.state); end
      tick(1);
      checks++;
      if (bus.fault !== 1'b1 || bus.brake !== 1'b1 || bus.duty !== 8'd0 || bus.pwm_open !== 1'b0) begin
         failures++; $display("FAIL tmo_outs flt=%b brk=%b duty=%0d po=%b required 1 1 0 0",
            bus.fault, bus.brake, bus.duty, bus.pwm_open);
      end
      bus.clr_fault = 1;
      tick(2);
      checks++;
      if (bus.state !== 3'd4) begin failures++; $display("FAIL clr_held state=%0d required 4", bus.state); end
      bus.ma_req = 0;
      tick(1);
      checks++;
      if (bus.state !== 3'd0) begin failures++; $display("FAIL clr_exit state=%0d required 0", bus.state); end
      bus.clr_fault = 0;
      tick(1);
      checks++;
      if (bus.fault !== 1'b0) begin failures++; $display("FAIL clr_fault_out fault=%b required 0", bus.fault); end
   endtask

   task automatic recover();
      clear_inputs(); bus.clr_fault = 1;
      tick(1);
      bus.clr_fault = 0;
      tick(1);
   endtask

   task automatic test_illegal();
      bus.ma_req = 1; bus.mc_req = 1;
      tick(1);
      checks++;
      if (bus.state !== 3'd4) begin failures++; $display("FAIL illegal_idle state=%0d required 4", bus.state); end
      recover();
      bus.ma_req = 1;
      tick(1);
      bus.mc_req = 1;
      tick(1);
      checks++;
      if (bus.state !== 3'd4) begin failures++; $display("FAIL illegal_dead state=%0d required 4", bus.state); end
      recover();
      bus.ma_req = 1;
      tick(5);
      bus.mc_req = 1; bus.la = 1;
      tick(1);
      checks++;
      if (bus.state !== 3'd4) begin failures++; $display("FAIL illegal_open state=%0d required 4", bus.state); end
      recover();
      checks++;
      if (bus.state !== 3'd0) begin failures++; $display("FAIL illegal_recover state=%0d required 0", bus.state); end
   endtask

   task automatic test_rst_mid();
      bus.ma_req = 1;
      tick(8);
      @(posedge clk); #2;
      rst = 1;
      #1;
      checks++;
      if ({bus.state, bus.duty, bus.pwm_open, bus.pwm_close, bus.brake, bus.fault} !== {3'd0, 8'd0, 4'b0010}) begin
         failures++; $display("FAIL rst_mid state=%0d duty=%0d po=%b pc=%b brk=%b flt=%b required 0 0 0 0 1 0",
            bus.state, bus.duty, bus.pwm_open, bus.pwm_close, bus.brake, bus.fault);
      end
      bus.ma_req = 0;
      tick(1);
      rst = 0;
      tick(1);
   endtask

   task automatic test_ena();
      bus.ma_req = 1;
      tick(1);
      bus.ena = 0;
      tick(10);
      checks++;
      if (bus.state !== 3'd1 || bus.brake !== 1'b1 || bus.pwm_open !== 1'b0) begin
         failures++; $display("FAIL ena_freeze state=%0d brk=%b po=%b required 1 1 0", bus.state, bus.brake, bus.pwm_open);
      end
      bus.ena = 1;
      tick(3);
      checks++;
      if (bus.state !== 3'd1) begin failures++; $display("FAIL ena_resume_dead state=%0d required 1", bus.state); end
      tick(1);
      checks++;
      if (bus.state !== 3'd2) begin failures++; $display("FAIL ena_resume_run state=%0d required 2", bus.state); end
      bus.ma_req = 0;
      tick(2);
   endtask

   task automatic test_limit_blocks_start();
      bus.mc_req = 1; bus.lc = 1;
      tick(3);
      checks++;
      if (bus.state !== 3'd0) begin failures++; $display("FAIL lim_block state=%0d required 0", bus.state); end
      clear_inputs();
      tick(1);
   endtask

   initial begin
      test_reset();
      test_open_ramp();
      test_limit();
      test_reversal();
      test_timeout();
      test_illegal();
      test_rst_mid();
      test_ena();
      test_limit_blocks_start();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
